host_mem_avmm_responder: RTL

- Avalon-MM read/write-split responder (slave) that terminates the AFU's host-memory master channel against on-chip RAM.
- Stands in for the PIM host channel in simulation and board bring-up; the kernel-system host-memory master connects to it unchanged.
- Enforces and flags the host-channel burst rules: no zero-length bursts, no page-crossing bursts.

---
 rtl/host_mem_avmm_responder_pkg.sv | 27 ++
 rtl/host_mem_resp_ram.sv | 44 ++++
 rtl/host_mem_avmm_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/host_mem_avmm_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : host_mem_avmm_responder_pkg
// Brief    : State encodings and burst-rule helpers shared by the responder.
// Revision : 1.0 - initial release
// ============================================================================
package host_mem_avmm_responder_pkg;

    typedef logic [0:0] t_rd_state;
    localparam t_rd_state RD_IDLE  = 1'b0;
    localparam t_rd_state RD_BURST = 1'b1;

    typedef logic [0:0] t_wr_state;
    localparam t_wr_state WR_IDLE  = 1'b0;
    localparam t_wr_state WR_BURST = 1'b1;

    // True when a burst of len lines starting at start spills past a page end.
    function automatic logic f_page_cross(input logic [63:0] start,
                                          input logic [31:0] len,
                                          input logic [31:0] page_lines);
        logic [63:0] w_offset;
        w_offset = start % {32'd0, page_lines};
        return (w_offset + {32'd0, len}) > {32'd0, page_lines};
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_mem_resp_ram.sv
`default_nettype none
// ============================================================================
// Module   : host_mem_resp_ram
// Brief    : Byte-enabled simple dual-port RAM, registered read, old data on
//            same-line read-during-write.
// Revision : 1.0 - initial release
// ============================================================================
module host_mem_resp_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic                    i_re,
    input  logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int c_lanes = DATA_WIDTH / 8;
    localparam int c_depth = 1 << ADDR_WIDTH;

    // One independent byte-wide array per lane keeps the byte enables a plain
    // per-array write enable.
    for (genvar g = 0; g < c_lanes; g++) begin : g_lane
        logic [7:0] r_mem [c_depth];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_we && i_be[g]) begin
                r_mem[i_waddr] <= i_wdata[g*8 +: 8];
            end
            if (i_re) begin
                r_q <= r_mem[i_raddr];
            end
        end

        assign o_rdata[g*8 +: 8] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/host_mem_avmm_responder.sv
`default_nettype none
// ============================================================================
// Module   : host_mem_avmm_responder
// Brief    : Avalon-MM read/write-split host-memory responder backed by RAM.
// Revision : 1.0 - initial release
// ============================================================================
module host_mem_avmm_responder #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 6,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int PAGE_LINES      = 64
) (
    input  logic                       pClk,
    input  logic                       pClk_reset,
    input  logic [ADDR_WIDTH-1:0]      rd_address,
    input  logic                       rd_read,
    input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
    output logic                       rd_waitrequest,
    output logic [DATA_WIDTH-1:0]      rd_readdata,
    output logic                       rd_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]      wr_address,
    input  logic                       wr_write,
    input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
    input  logic [DATA_WIDTH-1:0]      wr_writedata,
    input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
    output logic                       wr_waitrequest,
    output logic                       wr_writeresponsevalid,
    output logic                       err_burst_zero,
    output logic                       err_page_cross,
    output logic [31:0]                rd_burst_cnt,
    output logic [31:0]                wr_burst_cnt
);

    import host_mem_avmm_responder_pkg::*;

    localparam logic [BURST_CNT_WIDTH-1:0] c_len_one  = BURST_CNT_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0]  c_addr_one = MEM_ADDR_WIDTH'(1);

    logic                       r_rst_hold;

    t_rd_state                  r_rd_state;
    t_rd_state                  w_rd_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0]  r_rd_addr;
    logic [BURST_CNT_WIDTH-1:0] r_rd_rem;
    logic [BURST_CNT_WIDTH-1:0] w_rd_len;
    logic                       r_rd_vld;
    logic                       w_rd_wait;
    logic                       w_rd_accept;
    logic                       w_rd_issue;
    logic                       w_rd_page_cross;
    logic [31:0]                r_rd_cnt;

    t_wr_state                  r_wr_state;
    t_wr_state                  w_wr_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0]  r_wr_addr;
    logic [MEM_ADDR_WIDTH-1:0]  w_wr_waddr;
    logic [BURST_CNT_WIDTH-1:0] r_wr_rem;
    logic [BURST_CNT_WIDTH-1:0] w_wr_len;
    logic                       w_wr_beat;
    logic                       w_wr_first;
    logic                       w_wr_last;
    logic                       w_wr_page_cross;
    logic                       r_wr_resp;
    logic [31:0]                r_wr_cnt;

    logic                       r_err_zero;
    logic                       r_err_page;

    // Registered copy of reset: holds both channels off for the reset cycles
    // and releases them on the first cycle after reset drops.
    always_ff @(posedge pClk) begin
        r_rst_hold <= pClk_reset;
    end

    assign w_rd_len  = (rd_burstcount == '0) ? c_len_one : rd_burstcount;
    assign w_wr_len  = (wr_burstcount == '0) ? c_len_one : wr_burstcount;
    assign w_rd_page_cross = f_page_cross(64'(rd_address), 32'(w_rd_len), 32'(PAGE_LINES));
    assign w_wr_page_cross = f_page_cross(64'(wr_address), 32'(w_wr_len), 32'(PAGE_LINES));

    // ---------------------------------------------------------------- read FSM
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_wait      = r_rst_hold;
        w_rd_issue     = 1'b0;
        w_rd_accept    = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                w_rd_accept = rd_read && !r_rst_hold;
                if (w_rd_accept) begin
                    w_rd_state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                w_rd_wait  = 1'b1;
                w_rd_issue = 1'b1;
                if (r_rd_rem == c_len_one) begin
                    w_rd_state_nxt = RD_IDLE;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            r_rd_state <= RD_IDLE;
            r_rd_vld   <= 1'b0;
            r_rd_cnt   <= 32'd0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_vld   <= w_rd_issue;
            if (w_rd_accept) begin
                r_rd_addr <= rd_address[MEM_ADDR_WIDTH-1:0];
                r_rd_rem  <= w_rd_len;
                r_rd_cnt  <= r_rd_cnt + 32'd1;
            end else if (w_rd_issue) begin
                r_rd_addr <= r_rd_addr + c_addr_one;
                r_rd_rem  <= r_rd_rem - c_len_one;
            end
        end
    end

    // --------------------------------------------------------------- write FSM
    assign w_wr_beat = wr_write && !r_rst_hold;

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_waddr     = r_wr_addr;
        w_wr_first     = 1'b0;
        w_wr_last      = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_wr_waddr = wr_address[MEM_ADDR_WIDTH-1:0];
                if (w_wr_beat) begin
                    w_wr_first = 1'b1;
                    if (w_wr_len == c_len_one) begin
                        w_wr_last = 1'b1;
                    end else begin
                        w_wr_state_nxt = WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (w_wr_beat && (r_wr_rem == c_len_one)) begin
                    w_wr_last      = 1'b1;
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            r_wr_state <= WR_IDLE;
            r_wr_resp  <= 1'b0;
            r_wr_cnt   <= 32'd0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_resp  <= w_wr_last;
            if (w_wr_last) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (w_wr_first) begin
                r_wr_addr <= w_wr_waddr + c_addr_one;
                r_wr_rem  <= w_wr_len - c_len_one;
            end else if (w_wr_beat) begin
                r_wr_addr <= r_wr_addr + c_addr_one;
                r_wr_rem  <= r_wr_rem - c_len_one;
            end
        end
    end

    // ------------------------------------------------------------ error flags
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            r_err_zero <= 1'b0;
            r_err_page <= 1'b0;
        end else begin
            if ((w_rd_accept && (rd_burstcount == '0)) ||
                (w_wr_first && (wr_burstcount == '0))) begin
                r_err_zero <= 1'b1;
            end
            if ((w_rd_accept && w_rd_page_cross) || (w_wr_first && w_wr_page_cross)) begin
                r_err_page <= 1'b1;
            end
        end
    end

    host_mem_resp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_ram (
        .clk     (pClk),
        .i_we    (w_wr_beat),
        .i_waddr (w_wr_waddr),
        .i_wdata (wr_writedata),
        .i_be    (wr_byteenable),
        .i_re    (w_rd_issue),
        .i_raddr (r_rd_addr),
        .o_rdata (rd_readdata)
    );

    assign rd_waitrequest        = w_rd_wait;
    assign rd_readdatavalid      = r_rd_vld;
    assign wr_waitrequest        = r_rst_hold;
    assign wr_writeresponsevalid = r_wr_resp;
    assign err_burst_zero        = r_err_zero;
    assign err_page_cross        = r_err_page;
    assign rd_burst_cnt          = r_rd_cnt;
    assign wr_burst_cnt          = r_wr_cnt;

endmodule
`default_nettype wire
